router_sync_ctrl: RTL and testbench
===================================

// Module: router_sync_ctrl
// PURPOSE
//   Parametrised write-steering and output-watchdog controller for the packet router.
//   - Latches the destination address of each packet.
//   - Steers the FSM write enable to one of NUM_CH output FIFOs and returns that FIFO's full flag.
//   - Publishes a per-channel valid from each FIFO's empty flag.
//   - Runs a per-channel stall watchdog that soft-resets a FIFO whose data sits unread for TIMEOUT cycles.
//   - Sits between the router FSM / register block and the output FIFO array.
// PARAMETERS
//   NUM_CH   3                         number of output channels/FIFOs, legal 2..8
//   ADDR_W   $clog2(NUM_CH) (min 1)    width of din; codes >= NUM_CH are invalid
//   TIMEOUT  30                        stalled cycles before soft reset, legal 2..1023
//   CNT_W    $clog2(TIMEOUT)           watchdog counter width (derived, not overridden)
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   din          in   ADDR_W  destination address field of header byte
//   detect_addr  in   1       header present; load din this cycle
//   wr_en_reg    in   1       FSM write request for the current packet byte
//   full         in   NUM_CH  per-FIFO full flags
//   empty        in   NUM_CH  per-FIFO empty flags
//   rd_en        in   NUM_CH  per-FIFO read enables from the output side
//   wr_en        out  NUM_CH  one-hot FIFO write enable (combinational)
//   fifo_full    out  1       full flag of the addressed FIFO (combinational)
//   vld_out      out  NUM_CH  vld_out[i] = ~empty[i]
//   soft_reset   out  NUM_CH  one-cycle registered soft reset per FIFO
//   addr_err     out  1       only with ROUTER_SYNC_ADDR_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//   Reset:
//   - rst=1 asynchronously clears dest_q, all watchdog counters, soft_reset and addr_err to 0.
//   - During reset: wr_en = (wr_en_reg ? 1 : 0) on channel 0 per the rules below; vld_out tracks empty.
//   Address latch:
//   - dest_q <= din on every clk edge with detect_addr=1; otherwise dest_q holds.
//   - The new address steers from the cycle after detect_addr (1-cycle latency).
//   Steering:
//   - If dest_q < NUM_CH: fifo_full = full[dest_q]; wr_en = wr_en_reg ? (1<<dest_q) : 0.
//   - If dest_q >= NUM_CH: fifo_full = 0 and wr_en = 0, so the packet is dropped.
//   - wr_en is never multi-hot. full is not gated here; the FSM stalls on fifo_full.
//   Watchdog, independent per channel i; stall_i = vld_out[i] & ~rd_en[i]:
//   - stall_i=0 (FIFO empty or being read): cnt_i <= 0.
//   - stall_i=1 and cnt_i < TIMEOUT-1: cnt_i <= cnt_i+1.
//   - stall_i=1 and cnt_i == TIMEOUT-1: soft_reset[i] <= 1 and cnt_i <= 0.
//   - soft_reset[i] is 0 in every other cycle, i.e. an exactly one-cycle pulse.
//   - The pulse is high in the cycle after the TIMEOUT-th consecutive stalled cycle.
//   - A read in any cycle restarts the count from 0.
//   - If the stall persists (FIFO not yet cleared), another pulse follows TIMEOUT cycles later.
//   - Simultaneous pulses on several channels are legal.
//   Mid-operation reset: a counter at any value returns to 0 and no pulse is emitted.
// CONFIGURATION
//   ROUTER_SYNC_ADDR_ERR_EN defined:
//   - Port addr_err is present, registered.
//   - Set at the edge where detect_addr=1 and din >= NUM_CH.
//   - Cleared at the edge where detect_addr=1 and din < NUM_CH; holds otherwise.
//   ROUTER_SYNC_ADDR_ERR_EN undefined:
//   - Port addr_err and its flop do not exist.
//   - Invalid addresses still drop silently as above.
//   Steering and watchdog behaviour are identical in both builds.
// STRUCTURE
//   - router_pkg: ROUTER_NUM_CH_MAX=8 and the ROUTER_TIMEOUT_DEF=30 constant.
//   - router_pkg: function onehot(addr, n) used for wr_en.
//   - Sub-module router_sync_wdog: one channel's counter and pulse, params TIMEOUT/CNT_W,
//     ports clk, rst, vld, rd_en, soft_reset.
//   - Top instantiates router_sync_wdog NUM_CH times in a generate loop.
//   - Top keeps the address latch and the steering mux.
// TESTING (NUM_CH=3, TIMEOUT=30 unless noted)
//   1. Reset: rst=1 mid-count (cnt_1=17) -> soft_reset=0 and dest_q=0; after release, stall needs a full 30 cycles.
//   2. Steering: detect_addr with din=2, next cycle wr_en_reg=1 and full=3'b100
//      -> wr_en=3'b100 and fifo_full=1; din=3 -> wr_en=0 and fifo_full=0.
//   3. Watchdog: empty[0]=0, rd_en[0]=0 held -> soft_reset[0] high for exactly 1 cycle, 30 cycles after stall start;
//      repeats every 30 cycles while the stall persists.
//   4. Read restart: stall 29 cycles, rd_en[0]=1 for 1 cycle, stall again -> no pulse until 30 more stalled cycles.
//   5. Multi-channel: channels 0 and 2 stall from the same cycle -> both pulses coincide; channel 1 stays 0.
//   6. NUM_CH=5, TIMEOUT=4, ROUTER_SYNC_ADDR_ERR_EN on:
//      din=6 -> addr_err=1 and wr_en=0; then din=4 -> addr_err=0 and wr_en=5'b10000; stall pulses every 4 cycles.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and the steering one-hot helper for the packet router sync block.
package router_pkg;

    localparam int unsigned ROUTER_NUM_CH_MAX  = 8;
    localparam int unsigned ROUTER_TIMEOUT_DEF = 30;

    // One-hot of addr over n channels; all zero when addr is not a valid channel.
    function automatic logic [ROUTER_NUM_CH_MAX-1:0] onehot(
        input logic [$clog2(ROUTER_NUM_CH_MAX)-1:0] addr,
        input int unsigned                          n
    );
        onehot = '0;
        if (32'(addr) < n) begin
            onehot[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Single-channel stall watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid-but-unread data.
module router_sync_wdog #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd_en,
    output logic soft_reset
);

    logic             stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;

    assign stall = vld & ~rd_en;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!stall) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            soft_reset <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            soft_reset <= pulse_d;
        end
    end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router write-steering mux, address latch and per-channel stall watchdogs.
// Optional addr_err flag is built when ROUTER_SYNC_ADDR_ERR_EN is defined.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ADDR_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    parameter int unsigned TIMEOUT = ROUTER_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] din,
    input  logic              detect_addr,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    ,
    output logic              addr_err
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned SEL_W = $clog2(ROUTER_NUM_CH_MAX);

    logic [ADDR_W-1:0]            dest_q;
    logic [ROUTER_NUM_CH_MAX-1:0] dest_oh;
    logic [ROUTER_NUM_CH_MAX-1:0] full_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q <= '0;
        end else if (detect_addr) begin
            dest_q <= din;
        end
    end

    // Invalid destinations decode to all-zero, which drops the packet and masks full.
    always_comb begin
        dest_oh   = onehot(SEL_W'(dest_q), NUM_CH);
        full_ext  = ROUTER_NUM_CH_MAX'(full);
        fifo_full = |(dest_oh & full_ext);
        wr_en     = NUM_CH'(dest_oh) & {NUM_CH{wr_en_reg}};
    end

    assign vld_out = ~empty;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_wdog (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld_out[i]),
            .rd_en      (rd_en[i]),
            .soft_reset (soft_reset[i])
        );
    end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (detect_addr) begin
            addr_err <= !(32'(din) < NUM_CH);
        end
    end
`else
    // Without the flag, invalid addresses are dropped silently by the steering mux.
`endif

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Bench for router_sync_ctrl: a 3-channel/TIMEOUT=30 instance and a 5-channel/TIMEOUT=4 instance.
module tb_router_sync_ctrl;

    localparam int unsigned TO1 = 30;
    localparam int unsigned TO2 = 4;

    logic       clk = 1'b0;
    logic       rst;

    logic [1:0] din;
    logic       detect_addr, wr_en_reg;
    logic [2:0] full, empty, rd_en;
    logic [2:0] wr_en, vld_out, soft_reset;
    logic       fifo_full;

    logic [2:0] din2;
    logic       detect2, wr_en_reg2;
    logic [4:0] full2, empty2, rd_en2;
    logic [4:0] wr_en2, vld2, sr2;
    logic       fifo_full2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic       addr_err, addr_err2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] din;
        logic       wr_en_reg;
        logic [2:0] full;
        logic [2:0] exp_wr_en;
        logic       exp_fifo_full;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[7];
    sb_t  sbq[$];

    always #5 clk = ~clk;

    router_sync_ctrl #(.NUM_CH(3), .TIMEOUT(TO1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .detect_addr (detect_addr),
        .wr_en_reg   (wr_en_reg),
        .full        (full),
        .empty       (empty),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .fifo_full   (fifo_full),
        .vld_out     (vld_out),
        .soft_reset  (soft_reset)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        ,
        .addr_err    (addr_err)
`endif
    );

    router_sync_ctrl #(.NUM_CH(5), .TIMEOUT(TO2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .din         (din2),
        .detect_addr (detect2),
        .wr_en_reg   (wr_en_reg2),
        .full        (full2),
        .empty       (empty2),
        .rd_en       (rd_en2),
        .wr_en       (wr_en2),
        .fifo_full   (fifo_full2),
        .vld_out     (vld2),
        .soft_reset  (sr2)
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        ,
        .addr_err    (addr_err2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'd2, 1'b1, 3'b100, 3'b100, 1'b1};
        vecs[1] = '{2'd3, 1'b1, 3'b111, 3'b000, 1'b0};
        vecs[2] = '{2'd0, 1'b1, 3'b001, 3'b001, 1'b1};
        vecs[3] = '{2'd1, 1'b0, 3'b010, 3'b000, 1'b1};
        vecs[4] = '{2'd1, 1'b1, 3'b101, 3'b010, 1'b0};
        vecs[5] = '{2'd0, 1'b1, 3'b110, 3'b001, 1'b0};
        vecs[6] = '{2'd2, 1'b0, 3'b011, 3'b000, 1'b0};

        rst = 1'b1;
        din = '0; detect_addr = 0; wr_en_reg = 1; full = '0; empty = 3'b111; rd_en = '0;
        din2 = '0; detect2 = 0; wr_en_reg2 = 0; full2 = '0; empty2 = '1; rd_en2 = '0;
        #1;
        // Reset state: channel 0 steered, no pulses, valid tracks empty.
        chk("rst_soft_reset", 32'(soft_reset), 32'(0));
        chk("rst_wr_en", 32'(wr_en), 32'(3'b001));
        chk("rst_vld_out", 32'(vld_out), 32'(0));
        empty = 3'b010;
        #1;
        chk("rst_vld_track", 32'(vld_out), 32'(3'b101));
        empty = 3'b111;
        wr_en_reg = 0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven steering through the scoreboard.
        foreach (vecs[i]) begin
            din = vecs[i].din;
            detect_addr = 1'b1;
            tick();
            detect_addr = 1'b0;
            din = ~vecs[i].din;
            wr_en_reg = vecs[i].wr_en_reg;
            full = vecs[i].full;
            sbq.push_back('{"steer_wr_en", 32'(vecs[i].exp_wr_en)});
            sbq.push_back('{"steer_fifo_full", 32'(vecs[i].exp_fifo_full)});
            #1;
            while (sbq.size() > 0) begin
                sb_t e;
                e = sbq.pop_front();
                if (e.name == "steer_wr_en") chk(e.name, 32'(wr_en), e.exp);
                else chk(e.name, 32'(fifo_full), e.exp);
            end
        end

        // One-cycle latency: the detect cycle still steers to the old address (2).
        din = 2'd1; detect_addr = 1'b1; wr_en_reg = 1'b1; full = '0;
        #1;
        chk("latency_old", 32'(wr_en), 32'(3'b100));
        tick();
        detect_addr = 1'b0;
        #1;
        chk("latency_new", 32'(wr_en), 32'(3'b010));
        wr_en_reg = 1'b0;

        // Persistent stall on channel 0: pulses after the 30th and 60th stalled edges.
        empty = 3'b110;
        for (int k = 1; k <= 2 * TO1 + 1; k++) begin
            tick();
            chk("wdog_ch0", 32'(soft_reset), (k % TO1 == 0) ? 32'(3'b001) : 32'(0));
        end
        empty = 3'b111;
        tick();

        // A read after 29 stalled cycles restarts the count.
        empty = 3'b110;
        for (int k = 1; k < TO1; k++) begin
            tick();
            chk("restart_pre", 32'(soft_reset), 32'(0));
        end
        rd_en = 3'b001;
        tick();
        chk("restart_read", 32'(soft_reset), 32'(0));
        rd_en = 3'b000;
        for (int k = 1; k <= TO1; k++) begin
            tick();
            chk("restart_post", 32'(soft_reset), (k == TO1) ? 32'(3'b001) : 32'(0));
        end
        empty = 3'b111;
        tick();

        // Channels 0 and 2 stall together; channel 1 stays quiet.
        empty = 3'b010;
        for (int k = 1; k <= TO1 + 1; k++) begin
            tick();
            chk("multi_ch", 32'(soft_reset), (k == TO1) ? 32'(3'b101) : 32'(0));
        end
        empty = 3'b111;
        tick();

        // Mid-count reset with cnt_1 = 17.
        din = 2'd2; detect_addr = 1'b1;
        tick();
        detect_addr = 1'b0;
        empty = 3'b101;
        for (int k = 1; k <= 17; k++) tick();
        #2;
        rst = 1'b1;
        wr_en_reg = 1'b1;
        #1;
        chk("midrst_soft_reset", 32'(soft_reset), 32'(0));
        chk("midrst_dest_cleared", 32'(wr_en), 32'(3'b001));
        tick();
        chk("midrst_hold", 32'(soft_reset), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        wr_en_reg = 1'b0;
        for (int k = 1; k <= TO1 + 1; k++) begin
            tick();
            chk("midrst_full_count", 32'(soft_reset), (k == TO1) ? 32'(3'b010) : 32'(0));
        end
        empty = 3'b111;
        tick();

        // Wide instance: invalid code 6, then valid code 4, then short-timeout stall.
        din2 = 3'd6; detect2 = 1'b1;
        tick();
        detect2 = 1'b0; wr_en_reg2 = 1'b1; full2 = 5'b11111;
        #1;
        chk("w_inv_wr_en", 32'(wr_en2), 32'(0));
        chk("w_inv_fifo_full", 32'(fifo_full2), 32'(0));
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("w_addr_err_set", 32'(addr_err2), 32'(1));
`endif
        din2 = 3'd4; detect2 = 1'b1;
        tick();
        detect2 = 1'b0;
        #1;
        chk("w_ok_wr_en", 32'(wr_en2), 32'(5'b10000));
        chk("w_ok_fifo_full", 32'(fifo_full2), 32'(1));
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        chk("w_addr_err_clr", 32'(addr_err2), 32'(0));
`endif
        wr_en_reg2 = 1'b0;
        empty2 = 5'b11110;
        for (int k = 1; k <= 2 * TO2 + 1; k++) begin
            tick();
            chk("w_wdog", 32'(sr2), (k % TO2 == 0) ? 32'(5'b00001) : 32'(0));
        end
        empty2 = '1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
